md_sched: RTL and testbench

- Multiply/divide sequencer for the 5-stage pipeline; sits beside the ALU in the E stage.
- Owns the HI/LO registers and models the multi-cycle latency of mult/div.
- Accepts one-cycle start requests from E and drives the busy flag that the hazard unit combines with its MD-instruction decode to stall PC/D/E/M/W.
- Holds the result internally and commits it to HI/LO when the latency expires.

---
 rtl/md_sched.sv | 142 ++++++++++++++
 tb/tb_md_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// Multiply/divide sequencer: owns HI/LO and holds the result until the mult/div latency expires.
// Optional MD_SCHED_CANCEL_EN adds a cancel input that flushes an in-flight op.
module md_sched #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
`ifdef MD_SCHED_CANCEL_EN
   input  logic        cancel,
`endif
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic             cancel_req;

`ifdef MD_SCHED_CANCEL_EN
   assign cancel_req = cancel;
`else
   assign cancel_req = 1'b0;
`endif

   // Datapath: result of the op presented on md_op, captured only when accepted.
   logic [63:0]        prod_s, prod_u;
   logic               div_zero, div_ovf;
   logic [31:0]        sdiv_b, udiv_b;
   logic signed [31:0] quot_s, rem_s;
   logic [31:0]        quot_u, rem_u;
   logic [31:0]        res_hi, res_lo;

   assign prod_s   = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
   assign prod_u   = {32'd0, src_a} * {32'd0, src_b};
   assign div_zero = (src_b == 32'd0);
   assign div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
   // Dividing the overflow case by 1 yields exactly the required 0x8000_0000 / 0.
   assign sdiv_b   = (div_zero || div_ovf) ? 32'd1 : src_b;
   assign udiv_b   = div_zero ? 32'd1 : src_b;
   assign quot_s   = $signed(src_a) / $signed(sdiv_b);
   assign rem_s    = $signed(src_a) % $signed(sdiv_b);
   assign quot_u   = src_a / udiv_b;
   assign rem_u    = src_a % udiv_b;

   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (md_op)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV:   {res_hi, res_lo} = div_zero ? {src_a, 32'hFFFF_FFFF} : {rem_s, quot_s};
         OP_DIVU:  {res_hi, res_lo} = div_zero ? {src_a, 32'hFFFF_FFFF} : {rem_u, quot_u};
         default:  ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      unique case (state_q)
         StIdle: begin
            if (start && !cancel_req) begin
               case (md_op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     pend_hi_d = res_hi;
                     pend_lo_d = res_lo;
                     cnt_d     = (md_op == OP_MULT || md_op == OP_MULTU) ? MULT_LOAD : DIV_LOAD;
                     state_d   = StRun;
                  end
                  OP_MTHI: hi_d = src_a;
                  OP_MTLO: lo_d = src_a;
                  default: ;
               endcase
            end
         end
         StRun: begin
            if (cancel_req) begin
               state_d   = StIdle;
               cnt_d     = '0;
               pend_hi_d = 32'd0;
               pend_lo_d = 32'd0;
            end else if (cnt_q == '0) begin
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = (state_q == StRun);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed table, corner sequences, randomized model compare.
module tb_md_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] src_a, src_b;
   logic        busy;
   logic [31:0] hi, lo;
`ifdef MD_SCHED_CANCEL_EN
   logic        cancel = 1'b0;
`endif

   md_sched dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
`ifdef MD_SCHED_CANCEL_EN
      .cancel(cancel),
`endif
      .md_op (md_op),
      .src_a (src_a),
      .src_b (src_b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          exp_busy;
   } vec_t;

   vec_t vecs[9];

   // Reference model state (cycle-level view of the architectural behaviour)
   logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
   bit          m_busy;
   int          m_left;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      md_op = op;
      src_a = a;
      src_b = b;
      tick();
      start = 1'b0;
      md_op = 3'($urandom);
      src_a = $urandom;
      src_b = $urandom;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 64) begin
         n++;
         tick();
      end
   endtask

   function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint      sa, sb, ua, ub, q, rm;
      logic [63:0] r, qv, rv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      r  = 64'd0;
      case (op)
         3'd0: r = sa * sb;
         3'd1: r = ua * ub;
         3'd2, 3'd3: begin
            if (b == 32'd0) begin
               r = {a, 32'hFFFF_FFFF};
            end else begin
               q  = (op == 3'd2) ? sa / sb : ua / ub;
               rm = (op == 3'd2) ? sa % sb : ua % ub;
               qv = q;
               rv = rm;
               r  = {rv[31:0], qv[31:0]};
            end
         end
         default: r = 64'd0;
      endcase
      return r;
   endfunction

   task automatic model_edge(input bit st, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b);
      bit          was_busy;
      logic [63:0] r;
      was_busy = m_busy;
      if (m_busy) begin
         if (m_left == 1) begin
            m_hi   = m_pend_hi;
            m_lo   = m_pend_lo;
            m_busy = 0;
         end else begin
            m_left--;
         end
      end
      if (!was_busy && st) begin
         if (op <= 3'd3) begin
            r         = ref_md(op, a, b);
            m_pend_hi = r[63:32];
            m_pend_lo = r[31:0];
            m_busy    = 1;
            m_left    = (op <= 3'd1) ? 5 : 10;
         end else if (op == 3'd4) begin
            m_hi = a;
         end else if (op == 3'd5) begin
            m_lo = a;
         end
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      vecs[0] = '{"multu_ffff_x2", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 5};
      vecs[1] = '{"mult_3_xm2", 3'd0, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
      vecs[2] = '{"mult_m1_xm1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 5};
      vecs[3] = '{"div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
      vecs[4] = '{"div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10};
      vecs[5] = '{"divu_7_0", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 10};
      vecs[6] = '{"div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10};
      vecs[7] = '{"div_m5_0", 3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 10};
      vecs[8] = '{"divu_100_3", 3'd3, 32'd100, 32'd3, 32'd1, 32'd33, 10};

      reset = 1'b0;
      start = 1'b0;
      md_op = 3'd0;
      src_a = 32'd0;
      src_b = 32'd0;
      #12;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      reset = 1'b1;
      tick();

      // MTHI then MTLO back to back
      start = 1'b1;
      md_op = 3'd4;
      src_a = 32'h1234_5678;
      tick();
      chk("mthi_hi", hi, 32'h1234_5678);
      chk("mthi_lo", lo, 32'd0);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      md_op = 3'd5;
      src_a = 32'h9ABC_DEF0;
      tick();
      start = 1'b0;
      chk("mtlo_lo", lo, 32'h9ABC_DEF0);
      chk("mtlo_hi", hi, 32'h1234_5678);
      chk("mtlo_busy", {31'd0, busy}, 32'd0);

      // MULT with operands changing afterwards and a start issued during RUN
      issue(3'd0, 32'd3, 32'hFFFF_FFFE);
      chk("run_hi_held", hi, 32'h1234_5678);
      tick();
      start = 1'b1;
      md_op = 3'd3;
      src_a = 32'd100;
      src_b = 32'd3;
      tick();
      start = 1'b0;
      count_busy(n);
      chk("ign_busy_len", 32'(n + 2), 32'd5);
      chk("ign_hi", hi, 32'hFFFF_FFFF);
      chk("ign_lo", lo, 32'hFFFF_FFFA);
      for (int i = 0; i < 12; i++) tick();
      chk("ign_late_busy", {31'd0, busy}, 32'd0);
      chk("ign_late_hi", hi, 32'hFFFF_FFFF);
      chk("ign_late_lo", lo, 32'hFFFF_FFFA);

      // Directed table
      for (int i = 0; i < 9; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         count_busy(n);
         chk({vecs[i].name, "_busy_len"}, 32'(n), 32'(vecs[i].exp_busy));
         chk({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
         chk({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
      end

      // Asynchronous reset in the middle of a DIV
      issue(3'd2, 32'd100, 32'd7);
      for (int i = 0; i < 4; i++) tick();
      chk("arst_pre_busy", {31'd0, busy}, 32'd1);
      #3;
      reset = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      #2;
      reset = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("arst_stale_hi", hi, 32'd0);
         chk("arst_stale_lo", lo, 32'd0);
      end
      chk("arst_post_busy", {31'd0, busy}, 32'd0);

`ifdef MD_SCHED_CANCEL_EN
      issue(3'd0, 32'd6, 32'd7);
      tick();
      tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      chk("cancel_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 8; i++) tick();
      chk("cancel_hi", hi, 32'd0);
      chk("cancel_lo", lo, 32'd0);
      start  = 1'b1;
      md_op  = 3'd4;
      src_a  = 32'hDEAD_BEEF;
      cancel = 1'b1;
      tick();
      start  = 1'b0;
      cancel = 1'b0;
      chk("cancel_mthi_hi", hi, 32'd0);
      issue(3'd0, 32'd6, 32'd7);
      count_busy(n);
      chk("recommit_busy_len", 32'(n), 32'd5);
      chk("recommit_hi", hi, 32'd0);
      chk("recommit_lo", lo, 32'd42);
`endif

      // Randomized run against the reference model, from a clean reset
      reset = 1'b0;
      tick();
      reset = 1'b1;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      m_busy = 0;
      m_left = 0;
      for (int i = 0; i < 3000; i++) begin
         bit          st;
         logic [2:0]  op;
         logic [31:0] a, b;
         st    = ($urandom_range(0, 3) == 0);
         op    = 3'($urandom_range(0, 7));
         a     = pick();
         b     = pick();
         start = st;
         md_op = op;
         src_a = a;
         src_b = b;
         @(posedge clk);
         model_edge(st, op, a, b);
         #1;
         chk("rnd_busy", {31'd0, busy}, {31'd0, m_busy});
         chk("rnd_hi", hi, m_hi);
         chk("rnd_lo", lo, m_lo);
      end
      start = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
